// File: rtl/alu_wb_fifo.sv
// alu_wb_fifo: in-order result buffer between the integer ALU and the shared
// writeback port. It stores {trans_id, result, branch_res} whenever the ALU
// offers a result and there is room. It shows the oldest entry on the wb_*
// valid/ready port. Every output comes from a flop or from a mux on the read
// pointer, so no alu_* input reaches a wb_* output in the same cycle.
`timescale 1ns/1ps

module alu_wb_fifo #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic                       alu_branch_res_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [XLEN-1:0]            wb_result_o,
  output logic                       wb_branch_res_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic                     branch_res;
  } entry_t;

  entry_t        storage [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic          push, pop;
  logic          empty_nxt, full_nxt;

  // Full comes from a flop, so wb_ready_i has no path to alu_ready_o.
  assign alu_ready_o = ~full_o;
  assign push        = alu_valid_i & ~full_o;
  assign pop         = wb_valid_o & wb_ready_i;

  // Next-pointer logic. Flush returns both pointers to zero and overrides push and pop.
  always_comb begin
    // NOTE: give every variable a default at the top of always_comb, so a branch
    // that skips an assignment cannot infer a latch.
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush_i) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
    end
  end

  // The MSB of each pointer is a wrap bit. Equal pointers mean empty. Equal low
  // bits with different wrap bits mean full.
  assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
  assign full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  // Pointer and status registers. Reset takes priority over flush, and flush over push/pop.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge no matter how the blocks are ordered.
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      wb_valid_o <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count_o    <= wr_ptr_nxt - rd_ptr_nxt;
      empty_o    <= empty_nxt;
      full_o     <= full_nxt;
      wb_valid_o <= ~empty_nxt;
    end
  end

  // Entry storage. A flush in the same cycle discards the incoming entry.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset. The pointers alone decide which
    // slots are live, and the head data is gated while the buffer is empty.
    if (push && !flush_i) begin
      storage[wr_ptr[AW-1:0]] <= '{trans_id:   alu_trans_id_i,
                                   result:     alu_result_i,
                                   branch_res: alu_branch_res_i};
    end
  end

  // The head entry reads as zero while the buffer is empty.
  assign head            = storage[rd_ptr[AW-1:0]];
  assign wb_trans_id_o   = wb_valid_o ? head.trans_id   : '0;
  assign wb_result_o     = wb_valid_o ? head.result     : '0;
  assign wb_branch_res_o = wb_valid_o ? head.branch_res : 1'b0;

  // Flags an upstream stage offering a result while the buffer is full. That
  // stage must keep holding the result until alu_ready_o returns.
  full_offer_c: cover property (@(posedge clk_i) disable iff (rst_i) alu_valid_i && full_o);

  // Occupancy can never exceed DEPTH.
  count_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) count_o <= PW'(DEPTH));

endmodule

// File: tb/tb_alu_wb_fifo.sv
// tb_alu_wb_fifo: directed vectors plus a random valid/ready soak for alu_wb_fifo.
// The stimulus process drives inputs just after each rising edge and makes the
// directed checks with hand-computed values. The monitor keeps a queue model
// of expected entries. On each falling edge it compares every DUT output with
// that model, then applies the inputs for the coming edge to the model.
`timescale 1ns/1ps

module tb_alu_wb_fifo;

  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] res;
    logic        br;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        alu_valid_i, alu_ready_o;
  logic [2:0]  alu_trans_id_i;
  logic [63:0] alu_result_i;
  logic        alu_branch_res_i;
  logic        wb_valid_o, wb_ready_i;
  logic [2:0]  wb_trans_id_o;
  logic [63:0] wb_result_o;
  logic        wb_branch_res_o;
  logic [2:0]  count_o;
  logic        full_o, empty_o;

  int   n_vec = 0;
  int   n_bad = 0;
  ent_t exp_q[$];
  bit   model_live = 1'b0;

  alu_wb_fifo #(.XLEN(64), .TRANS_ID_BITS(3), .DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .alu_valid_i     (alu_valid_i),
    .alu_ready_o     (alu_ready_o),
    .alu_trans_id_i  (alu_trans_id_i),
    .alu_result_i    (alu_result_i),
    .alu_branch_res_i(alu_branch_res_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_trans_id_o   (wb_trans_id_o),
    .wb_result_o     (wb_result_o),
    .wb_branch_res_o (wb_branch_res_o),
    .count_o         (count_o),
    .full_o          (full_o),
    .empty_o         (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [2:0] id, input logic [63:0] res, input logic br);
    alu_valid_i      = v;
    alu_trans_id_i   = id;
    alu_result_i     = res;
    alu_branch_res_i = br;
  endtask

  // Monitor: compare against the model, then advance the model for the coming edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (model_live) begin
        int sz;
        sz = exp_q.size();
        check("alu_ready", 64'(alu_ready_o), 64'(sz < DEPTH));
        check("wb_valid",  64'(wb_valid_o),  64'(sz != 0));
        check("count",     64'(count_o),     64'(sz));
        check("full",      64'(full_o),      64'(sz == DEPTH));
        check("empty",     64'(empty_o),     64'(sz == 0));
        if (sz != 0) begin
          check("wb_trans_id", 64'(wb_trans_id_o), 64'(exp_q[0].id));
          check("wb_result",   wb_result_o,        exp_q[0].res);
          check("wb_branch",   64'(wb_branch_res_o), 64'(exp_q[0].br));
        end else begin
          check("wb_trans_id_zero", 64'(wb_trans_id_o), 64'd0);
          check("wb_result_zero",   wb_result_o,        64'd0);
          check("wb_branch_zero",   64'(wb_branch_res_o), 64'd0);
        end
      end
      if (rst_i) begin
        exp_q.delete();
        model_live = 1'b1;
      end else if (model_live) begin
        if (flush_i) begin
          exp_q.delete();
        end else begin
          bit do_push, do_pop;
          do_push = alu_valid_i && (exp_q.size() < DEPTH);
          do_pop  = wb_ready_i && (exp_q.size() != 0);
          if (do_pop) void'(exp_q.pop_front());
          if (do_push) exp_q.push_back('{id: alu_trans_id_i, res: alu_result_i, br: alu_branch_res_i});
        end
      end
    end
  end

  // Stimulus and directed checks.
  initial begin
    rst_i = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b0;
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    tick(); tick();
    rst_i = 1'b0;
    tick();
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_valid", 64'(wb_valid_o), 64'd0);
    check("rst_ready", 64'(alu_ready_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_result", wb_result_o, 64'd0);

    // Single entry held while writeback is busy.
    set_alu(1'b1, 3'd3, 64'hDEAD_BEEF_0000_0001, 1'b1);
    tick();
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(wb_valid_o), 64'd1);
      check("hold_id", 64'(wb_trans_id_o), 64'd3);
      check("hold_result", wb_result_o, 64'hDEAD_BEEF_0000_0001);
      check("hold_br", 64'(wb_branch_res_o), 64'd1);
      tick();
    end
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    check("drain1_empty", 64'(empty_o), 64'd1);

    // Fill to full. A fifth push is ignored, then the entries drain in order.
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 3'(i), 64'(10 + i), 1'b0);
      tick();
    end
    check("fill_full", 64'(full_o), 64'd1);
    check("fill_ready", 64'(alu_ready_o), 64'd0);
    check("fill_count", 64'(count_o), 64'd4);
    set_alu(1'b1, 3'd7, 64'd99, 1'b1);
    tick();
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    check("fifth_count", 64'(count_o), 64'd4);
    check("fifth_head", 64'(wb_trans_id_o), 64'd0);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_id", 64'(wb_trans_id_o), 64'(i));
      check("drain_res", wb_result_o, 64'(10 + i));
      tick();
    end
    wb_ready_i = 1'b0;
    check("drain_empty", 64'(empty_o), 64'd1);

    // Push and pop together while full: only the pop happens.
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 3'(i), 64'(20 + i), 1'b0);
      tick();
    end
    set_alu(1'b1, 3'd6, 64'd30, 1'b1);
    wb_ready_i = 1'b1;
    tick();
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    wb_ready_i = 1'b0;
    check("fullpp_count", 64'(count_o), 64'd3);
    check("fullpp_full", 64'(full_o), 64'd0);
    check("fullpp_head", wb_result_o, 64'd21);
    wb_ready_i = 1'b1;
    tick();
    check("steady_pre_count", 64'(count_o), 64'd2);

    // Push and pop every cycle at count 2, across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      set_alu(1'b1, 3'(i % 8), 64'(100 + i), 1'(i % 2));
      tick();
      check("steady_count", 64'(count_o), 64'd2);
    end
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    wb_ready_i = 1'b0;
    tick();
    check("steady_head", wb_result_o, 64'd118);

    // Flush together with a push and a pop.
    set_alu(1'b1, 3'd1, 64'd200, 1'b0);
    tick();
    check("preflush_count", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    set_alu(1'b1, 3'd2, 64'd201, 1'b1);
    wb_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    wb_ready_i = 1'b0;
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(wb_valid_o), 64'd0);
    set_alu(1'b1, 3'd5, 64'd500, 1'b1);
    tick();
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    check("postflush_id", 64'(wb_trans_id_o), 64'd5);
    check("postflush_res", wb_result_o, 64'd500);
    check("postflush_count", 64'(count_o), 64'd1);

    // Reset with two entries stored and a push in flight.
    set_alu(1'b1, 3'd4, 64'd400, 1'b0);
    tick();
    check("prereset_count", 64'(count_o), 64'd2);
    rst_i = 1'b1;
    set_alu(1'b1, 3'd6, 64'd600, 1'b1);
    tick();
    rst_i = 1'b0;
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    check("rst2_empty", 64'(empty_o), 64'd1);
    check("rst2_valid", 64'(wb_valid_o), 64'd0);
    check("rst2_ready", 64'(alu_ready_o), 64'd1);
    check("rst2_count", 64'(count_o), 64'd0);
    check("rst2_full", 64'(full_o), 64'd0);
    check("rst2_result", wb_result_o, 64'd0);

    // Random valid/ready soak. The monitor checks order, loss and duplication.
    for (int i = 0; i < 10000; i++) begin
      set_alu(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      wb_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    set_alu(1'b0, 3'd0, 64'd0, 1'b0);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("final_empty", 64'(empty_o), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
